// File: rtl/sum_pipe.sv
// Two-entry skid buffer computing a+b with carry, 1-cycle latency, plus a
// Gray-coded count of completed output handshakes.
module sum_pipe #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     y,
    output logic                 carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           state_onehot,
    output logic [CNT_WIDTH-1:0] gray_cnt
);

    localparam logic [2:0] ST_EMPTY = 3'b001;
    localparam logic [2:0] ST_ONE   = 3'b010;
    localparam logic [2:0] ST_FULL  = 3'b100;

    logic [2:0]           state;
    logic [WIDTH:0]       head;
    logic [WIDTH:0]       skid;
    logic [WIDTH:0]       sum;
    logic [CNT_WIDTH-1:0] bin;
    logic [CNT_WIDTH-1:0] bin_nxt;
    logic                 in_fire;
    logic                 out_fire;

    // Handshake flags are gated by rst so nothing is exchanged in a reset cycle.
    assign in_ready     = ~rst & (state == ST_EMPTY || state == ST_ONE);
    assign out_valid    = (state == ST_ONE) || (state == ST_FULL);
    assign in_fire      = in_valid & in_ready;
    assign out_fire     = out_valid & out_ready & ~rst;
    assign sum          = {1'b0, a} + {1'b0, b};
    assign bin_nxt      = bin + 1'b1;
    assign y            = head[WIDTH-1:0];
    assign carry        = head[WIDTH];
    assign state_onehot = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            head     <= '0;
            skid     <= '0;
            bin      <= '0;
            gray_cnt <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state <= ST_ONE;
                        head  <= sum;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head <= sum;
                    end else if (in_fire) begin
                        state <= ST_FULL;
                        skid  <= sum;
                    end else if (out_fire) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state <= ST_ONE;
                        head  <= skid;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
            if (out_fire) begin
                bin      <= bin_nxt;
                gray_cnt <= bin_nxt ^ (bin_nxt >> 1);
            end
        end
    end

endmodule
